axi4_lite_slave_regs: RTL and testbench

AXI4-Lite slave endpoint that terminates the transactions issued by the team's AXI4-Lite master. It holds a bank of NUM_REGS 32-bit control/status registers, applies byte strobes on writes, and returns OKAY/SLVERR responses. It is the downstream neighbour of the master on the same ACLK domain. Register contents are exported flat to the surrounding logic, together with per-register write pulses.

---
 rtl/axi4_lite_slave_regs_pkg.sv | 24 ++
 rtl/axi4_lite_slave_regs_if.sv | 36 +++
 rtl/axi4_lite_slave_regs_regfile.sv | 98 +++++++++
 rtl/axi4_lite_slave_regs.sv | 179 +++++++++++++++++
 tb/tb_axi4_lite_slave_regs.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_slave_regs_pkg.sv
// Shared definitions for the AXI4-Lite register slave: response codes,
// handshake FSM state types and a small response-encoding helper.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    WS_IDLE = 1'b0,
    WS_RESP = 1'b1
  } slv_wstate_t;

  typedef enum logic {
    RS_IDLE = 1'b0,
    RS_DATA = 1'b1
  } slv_rstate_t;

  // Map an access-accepted flag onto the AXI response code.
  function automatic logic [1:0] resp_of(input logic ok);
    return ok ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi4_lite_slave_regs_if.sv
// AXI4-Lite bus bundle between the team's master and the register slave.
interface axi4_lite_slave_regs_if;

  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        WVALID;
  logic        WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    input  ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    output ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

endinterface

// File: rtl/axi4_lite_slave_regs_regfile.sv
// Register bank behind the AXI4-Lite slave: strobe-masked write port,
// per-register write pulses, read mux with range check.
// Optional macro AXIL_SLAVE_ID_REG_EN turns register 0 into a read-only
// ID register returning ID_VALUE.
module axi4_lite_regfile #(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'hA11E_0001
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     wr_commit,
  input  logic [31:0]              wr_addr,
  input  logic [31:0]              wr_data,
  input  logic [3:0]               wr_strb,
  output logic                     wr_ok,
  input  logic [31:0]              rd_addr,
  output logic [31:0]              rd_data,
  output logic                     rd_ok,
  output logic [NUM_REGS*32-1:0]   regs_out,
  output logic [NUM_REGS-1:0]      reg_wr_pulse
);

  localparam int IDX_W = $clog2(NUM_REGS);

`ifdef AXIL_SLAVE_ID_REG_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
  // ID_VALUE has no consumer when the ID register is compiled out.
  logic unused_id;
  assign unused_id = ^ID_VALUE;
`endif

  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             wr_in_range;
  logic             rd_in_range;
  logic [31:0]      reg_val [NUM_REGS];

  // Byte lane bits of the address never select anything.
  logic unused_addr;
  assign unused_addr = ^{wr_addr[1:0], rd_addr[1:0]};

  assign wr_idx      = wr_addr[2 +: IDX_W];
  assign rd_idx      = rd_addr[2 +: IDX_W];
  assign wr_in_range = (wr_addr[31:IDX_W+2] == '0);
  assign rd_in_range = (rd_addr[31:IDX_W+2] == '0);

  // A write is accepted if it decodes to a register that is writable.
  assign wr_ok = wr_in_range && !(ID_EN && (wr_idx == '0));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (ID_EN && (gi == 0)) begin : g_id
        assign reg_val[gi]      = ID_VALUE;
        assign reg_wr_pulse[gi] = 1'b0;
      end else begin : g_rw
        logic [31:0] mem_reg;
        logic        pulse_reg;
        logic        hit;

        assign hit = wr_commit && wr_ok && (wr_idx == IDX_W'(gi));

        // Strobe-masked byte update of this register on a committed write.
        always_ff @(posedge ACLK or negedge ARESETn) begin
          if (!ARESETn) begin
            mem_reg <= '0;
          end else if (hit) begin
            for (int b = 0; b < 4; b++) begin
              if (wr_strb[b]) begin
                mem_reg[8*b +: 8] <= wr_data[8*b +: 8];
              end
            end
          end
        end

        // One-cycle pulse following any committed write, even with no strobes.
        always_ff @(posedge ACLK or negedge ARESETn) begin
          if (!ARESETn) begin
            pulse_reg <= 1'b0;
          end else begin
            pulse_reg <= hit;
          end
        end

        assign reg_val[gi]      = mem_reg;
        assign reg_wr_pulse[gi] = pulse_reg;
      end

      assign regs_out[32*gi +: 32] = reg_val[gi];
    end
  endgenerate

  assign rd_ok   = rd_in_range;
  assign rd_data = rd_in_range ? reg_val[rd_idx] : 32'h0;

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave register bank: write/read handshake FSMs and the AW/W
// holding registers; the register storage lives in axi4_lite_regfile.
// Optional macro AXIL_SLAVE_ID_REG_EN makes register 0 a read-only ID.
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'hA11E_0001
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  axi4_lite_slave_regs_if.slave  bus,
  output logic [NUM_REGS*32-1:0] regs_out,
  output logic [NUM_REGS-1:0]    reg_wr_pulse
);

  // Protection attributes carry no meaning for this register bank.
  logic unused_prot;
  assign unused_prot = ^{bus.AWPROT, bus.ARPROT};

  // ---------------------------------------------------------------- write
  slv_wstate_t wstate_reg, wstate_next;
  logic        aw_held_reg, w_held_reg;
  logic [31:0] awaddr_reg, wdata_reg;
  logic [3:0]  wstrb_reg;
  logic [1:0]  bresp_reg;
  logic        awready, wready, bvalid;
  logic        aw_hs, w_hs, wr_commit, wr_ok;
  logic [31:0] wr_addr_sel, wr_data_sel;
  logic [3:0]  wr_strb_sel;

  assign aw_hs     = bus.AWVALID && awready;
  assign w_hs      = bus.WVALID && wready;
  assign wr_commit = (wstate_reg == WS_IDLE) &&
                     (aw_held_reg || aw_hs) && (w_held_reg || w_hs);

  // The half that arrives last is taken straight from the bus.
  assign wr_addr_sel = aw_held_reg ? awaddr_reg : bus.AWADDR;
  assign wr_data_sel = w_held_reg  ? wdata_reg  : bus.WDATA;
  assign wr_strb_sel = w_held_reg  ? wstrb_reg  : bus.WSTRB;

  // Write FSM state register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) wstate_reg <= WS_IDLE;
    else          wstate_reg <= wstate_next;
  end

  // Write FSM next state: idle until the AW/W pair commits, then wait for B.
  always_comb begin
    wstate_next = wstate_reg;
    case (wstate_reg)
      WS_IDLE: if (wr_commit)   wstate_next = WS_RESP;
      WS_RESP: if (bus.BREADY)  wstate_next = WS_IDLE;
      default:                  wstate_next = WS_IDLE;
    endcase
  end

  // Write FSM outputs: each channel ready only while idle and not yet held.
  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (wstate_reg)
      WS_IDLE: begin
        awready = !aw_held_reg;
        wready  = !w_held_reg;
      end
      WS_RESP: bvalid = 1'b1;
      default: ;
    endcase
  end

  // AW/W holding registers; both flags drop on the commit edge.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
    end else if (wr_commit) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held_reg <= 1'b1;
        awaddr_reg  <= bus.AWADDR;
      end
      if (w_hs) begin
        w_held_reg <= 1'b1;
        wdata_reg  <= bus.WDATA;
        wstrb_reg  <= bus.WSTRB;
      end
    end
  end

  // Write response code, frozen for the whole WS_RESP phase.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)       bresp_reg <= RESP_OKAY;
    else if (wr_commit) bresp_reg <= resp_of(wr_ok);
  end

  assign bus.AWREADY = awready;
  assign bus.WREADY  = wready;
  assign bus.BVALID  = bvalid;
  assign bus.BRESP   = bresp_reg;

  // ----------------------------------------------------------------- read
  slv_rstate_t rstate_reg, rstate_next;
  logic [31:0] rdata_reg;
  logic [1:0]  rresp_reg;
  logic        arready, rvalid, ar_hs, rd_ok;
  logic [31:0] rd_data;

  assign ar_hs = bus.ARVALID && arready;

  // Read FSM state register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) rstate_reg <= RS_IDLE;
    else          rstate_reg <= rstate_next;
  end

  // Read FSM next state: one AR at a time, released by the R handshake.
  always_comb begin
    rstate_next = rstate_reg;
    case (rstate_reg)
      RS_IDLE: if (bus.ARVALID) rstate_next = RS_DATA;
      RS_DATA: if (bus.RREADY)  rstate_next = RS_IDLE;
      default:                  rstate_next = RS_IDLE;
    endcase
  end

  // Read FSM outputs.
  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    case (rstate_reg)
      RS_IDLE: arready = 1'b1;
      RS_DATA: rvalid  = 1'b1;
      default: ;
    endcase
  end

  // Read data/response captured at AR acceptance, so a same-edge write is not seen.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rdata_reg <= '0;
      rresp_reg <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_reg <= rd_data;
      rresp_reg <= resp_of(rd_ok);
    end
  end

  assign bus.ARREADY = arready;
  assign bus.RVALID  = rvalid;
  assign bus.RDATA   = rdata_reg;
  assign bus.RRESP   = rresp_reg;

  // ------------------------------------------------------------- regfile
  axi4_lite_regfile #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .ACLK         (ACLK),
    .ARESETn      (ARESETn),
    .wr_commit    (wr_commit),
    .wr_addr      (wr_addr_sel),
    .wr_data      (wr_data_sel),
    .wr_strb      (wr_strb_sel),
    .wr_ok        (wr_ok),
    .rd_addr      (bus.ARADDR),
    .rd_data      (rd_data),
    .rd_ok        (rd_ok),
    .regs_out     (regs_out),
    .reg_wr_pulse (reg_wr_pulse)
  );

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench for axi4_lite_slave_regs: directed cases plus random
// reads/writes compared against a byte-level register model.
module tb_axi4_lite_slave_regs;
  import axi4_lite_pkg::*;

  localparam int          NUM_REGS = 16;
  localparam logic [31:0] ID_VALUE = 32'hA11E_0001;
`ifdef AXIL_SLAVE_ID_REG_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  logic                   ACLK = 1'b0;
  logic                   ARESETn = 1'b0;
  logic [NUM_REGS*32-1:0] regs_out;
  logic [NUM_REGS-1:0]    reg_wr_pulse;

  axi4_lite_slave_regs_if bus();

  axi4_lite_slave_regs #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) dut (
    .ACLK         (ACLK),
    .ARESETn      (ARESETn),
    .bus          (bus),
    .regs_out     (regs_out),
    .reg_wr_pulse (reg_wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model_regs [NUM_REGS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (address arithmetic on byte addresses)
  function automatic bit mdl_in_range(input logic [31:0] a);
    return a < NUM_REGS * 4;
  endfunction

  function automatic bit mdl_writable(input logic [31:0] a);
    return mdl_in_range(a) && !(ID_EN && (a / 4 == 0));
  endfunction

  function automatic logic [31:0] mdl_view(input int i);
    if (ID_EN && i == 0) return ID_VALUE;
    return model_regs[i];
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    if (!mdl_in_range(a)) return 32'h0;
    return mdl_view(int'(a / 4));
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    if (mdl_writable(a)) begin
      idx = int'(a / 4);
      for (int b = 0; b < 4; b++)
        if (s[b]) model_regs[idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 32'h0;
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++)
      check($sformatf("%s_reg%0d", tag, i), regs_out[32*i +: 32], mdl_view(i));
  endtask

  // ---------------- bus tasks (drive and sample on the falling edge)
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly);
    int cyc;
    bit aw_done, w_done, aw_fire, w_fire;
    logic [1:0] exp_resp;
    logic [NUM_REGS-1:0] exp_pulse;
    exp_resp  = mdl_writable(addr) ? RESP_OKAY : RESP_SLVERR;
    exp_pulse = '0;
    if (mdl_writable(addr)) exp_pulse[int'(addr / 4)] = 1'b1;
    bus.AWADDR = addr; bus.WDATA = data; bus.WSTRB = strb; bus.AWPROT = 3'($urandom);
    cyc = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      bus.AWVALID = !aw_done && (cyc >= aw_dly);
      bus.WVALID  = !w_done && (cyc >= w_dly);
      if (aw_done) check("awready_while_held", bus.AWREADY, 1'b0);
      if (w_done)  check("wready_while_held", bus.WREADY, 1'b0);
      aw_fire = bus.AWVALID && bus.AWREADY;
      w_fire  = bus.WVALID && bus.WREADY;
      @(negedge ACLK);
      cyc++;
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
    end
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    if (!(aw_done && w_done)) begin
      check("aw_w_accept_timeout", 32'd0, 32'd1);
      return;
    end
    mdl_write(addr, data, strb);
    check("bvalid_latency", bus.BVALID, 1'b1);
    check("bresp", bus.BRESP, exp_resp);
    check("wr_pulse", reg_wr_pulse, exp_pulse);
    check_all_regs("wr");
    bus.BREADY = 1'b0;
    repeat (b_dly) begin
      @(negedge ACLK);
      check("bvalid_hold", bus.BVALID, 1'b1);
      check("bresp_hold", bus.BRESP, exp_resp);
      check("awready_in_resp", bus.AWREADY, 1'b0);
      check("wr_pulse_clear", reg_wr_pulse, '0);
    end
    bus.BREADY = 1'b1;
    @(negedge ACLK);
    bus.BREADY = 1'b0;
    check("bvalid_drop", bus.BVALID, 1'b0);
    check("wr_pulse_after", reg_wr_pulse, '0);
    $display("WR addr=0x%08h data=0x%08h strb=%b resp=%b", addr, data, strb, exp_resp);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_dly);
    int cyc;
    bit fire;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    exp_data = mdl_read(addr);
    exp_resp = mdl_in_range(addr) ? RESP_OKAY : RESP_SLVERR;
    bus.ARADDR = addr; bus.ARPROT = 3'($urandom); bus.ARVALID = 1'b1;
    cyc = 0; fire = 0;
    while (!fire && cyc < 40) begin
      fire = bus.ARREADY;
      @(negedge ACLK);
      cyc++;
    end
    bus.ARVALID = 1'b0;
    if (!fire) begin
      check("ar_accept_timeout", 32'd0, 32'd1);
      return;
    end
    check("rvalid_latency", bus.RVALID, 1'b1);
    check("rdata", bus.RDATA, exp_data);
    check("rresp", bus.RRESP, exp_resp);
    repeat (r_dly) begin
      @(negedge ACLK);
      check("rvalid_hold", bus.RVALID, 1'b1);
      check("rdata_hold", bus.RDATA, exp_data);
      check("arready_busy", bus.ARREADY, 1'b0);
    end
    bus.RREADY = 1'b1;
    @(negedge ACLK);
    bus.RREADY = 1'b0;
    check("rvalid_drop", bus.RVALID, 1'b0);
    check("arready_back", bus.ARREADY, 1'b1);
    $display("RD addr=0x%08h data=0x%08h resp=%b", addr, exp_data, exp_resp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    bus.AWVALID = 0; bus.WVALID = 0; bus.BREADY = 0; bus.ARVALID = 0; bus.RREADY = 0;
    bus.AWADDR = 0; bus.WDATA = 0; bus.WSTRB = 0; bus.ARADDR = 0;
    bus.AWPROT = 0; bus.ARPROT = 0;
    mdl_reset();

    // Reset values
    repeat (3) @(negedge ACLK);
    check("rst_bvalid", bus.BVALID, 1'b0);
    check("rst_rvalid", bus.RVALID, 1'b0);
    check("rst_bresp", bus.BRESP, 2'b00);
    check("rst_rresp", bus.RRESP, 2'b00);
    check("rst_rdata", bus.RDATA, 32'h0);
    check("rst_pulse", reg_wr_pulse, '0);
    check_all_regs("rst");
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("idle_awready", bus.AWREADY, 1'b1);
    check("idle_wready", bus.WREADY, 1'b1);
    check("idle_arready", bus.ARREADY, 1'b1);

    // AW and W in the same cycle
    axi_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check("reg1_deadbeef", regs_out[63:32], 32'hDEADBEEF);
    // AW first, W three cycles later, partial strobes
    axi_write(32'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_write(32'h08, 32'h11223344, 4'b0101, 0, 3, 1);
    check("reg2_strobed", regs_out[95:64], 32'hFF22FF44);
    // W before AW, zero strobes still pulses
    axi_write(32'h1B, 32'h55555555, 4'h0, 2, 0, 2);
    // Out of range
    axi_write(32'h40, 32'h12345678, 4'hF, 0, 0, 0);
    axi_read(32'h40, 0);
    // Read with back-pressure
    axi_read(32'h04, 4);
    // Register 0 (ID register when enabled)
    axi_read(32'h00, 0);
    axi_write(32'h00, 32'hCAFEF00D, 4'hF, 1, 1, 0);
    axi_read(32'h00, 1);
    if (ID_EN) check("id_reg_value", regs_out[31:0], 32'hA11E0001);

    // Read accepted on the edge a write to the same register commits
    axi_write(32'h0C, 32'h9, 4'hF, 0, 0, 0);
    bus.AWADDR = 32'h0C; bus.WDATA = 32'h5; bus.WSTRB = 4'hF; bus.ARADDR = 32'h0C;
    bus.AWVALID = 1; bus.WVALID = 1; bus.ARVALID = 1;
    check("same_edge_ready", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
    @(negedge ACLK);
    bus.AWVALID = 0; bus.WVALID = 0; bus.ARVALID = 0;
    mdl_write(32'h0C, 32'h5, 4'hF);
    check("same_edge_rvalid", bus.RVALID, 1'b1);
    check("same_edge_rdata_old", bus.RDATA, 32'h9);
    check("same_edge_bvalid", bus.BVALID, 1'b1);
    check("same_edge_reg3_new", regs_out[127:96], 32'h5);
    bus.BREADY = 1; bus.RREADY = 1;
    @(negedge ACLK);
    bus.BREADY = 0; bus.RREADY = 0;
    axi_read(32'h0C, 0);

    // Random traffic against the model
    for (int n = 0; n < 80; n++) begin
      a = 32'($urandom_range(0, NUM_REGS * 4 + 15));
      d = $urandom;
      if ($urandom_range(0, 1) == 1)
        axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(a, $urandom_range(0, 3));
    end

    // Reset while a write response is pending
    bus.AWADDR = 32'h10; bus.WDATA = 32'h77; bus.WSTRB = 4'hF;
    bus.AWVALID = 1; bus.WVALID = 1;
    @(negedge ACLK);
    bus.AWVALID = 0; bus.WVALID = 0;
    check("pre_reset_bvalid", bus.BVALID, 1'b1);
    ARESETn = 1'b0;
    #1;
    check("async_reset_bvalid", bus.BVALID, 1'b0);
    mdl_reset();
    check_all_regs("mid_reset");
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    bus.BREADY = 1'b1;
    repeat (2) @(negedge ACLK);
    check("no_resp_after_reset", bus.BVALID, 1'b0);
    bus.BREADY = 1'b0;
    axi_read(32'h10, 0);
    axi_read(32'h04, 0);
    axi_read(32'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
